// File: rtl/fpu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : fpu_rr_scheduler
// Brief   : Round-robin sharing of one combinational bfloat16 FPU among NREQ
//           requesters, with a tagged valid/ready response channel.
// Revision: 1.0
// ============================================================================
module fpu_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid_i,
  input  logic [4*NREQ-1:0]    req_op_i,
  input  logic [16*NREQ-1:0]   req_a_i,
  input  logic [16*NREQ-1:0]   req_b_i,
  output logic [NREQ-1:0]      req_ready_o,
  output logic                 resp_valid_o,
  input  logic                 resp_ready_i,
  output logic [IDW-1:0]       resp_id_o,
  output logic [15:0]          resp_data_o,
  output logic                 resp_overflow_o,
  output logic                 resp_err_o,
  output logic [3:0]           fpu_op_o,
  output logic [15:0]          fpu_in1_o,
  output logic [15:0]          fpu_in2_o,
  input  logic [15:0]          fpu_out_i,
  input  logic                 fpu_overflow_i
);

  localparam logic [15:0] c_qnan = 16'h7FC0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [IDW-1:0] r_ptr;
  logic [IDW-1:0] r_id;
  logic [3:0]     r_op;
  logic [15:0]    r_a;
  logic [15:0]    r_b;
  logic [15:0]    r_data;
  logic           r_ovf;
  logic           r_err;
  logic [IDW-1:0] w_win;
  logic           w_any;
  logic           w_grant;
  logic           w_op_onehot;

  function automatic logic [IDW-1:0] wrap_idx(input int s);
    return (s >= NREQ) ? IDW'(s - NREQ) : IDW'(s);
  endfunction

  // Scan starting at the pointer; the first valid requester wins.
  always_comb begin
    w_any = 1'b0;
    w_win = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!w_any && req_valid_i[wrap_idx(int'(r_ptr) + k)]) begin
        w_any = 1'b1;
        w_win = wrap_idx(int'(r_ptr) + k);
      end
    end
  end

  // Grant is suppressed during reset so no requester sees a phantom accept.
  assign w_grant     = (r_state == IDLE) && w_any && !rst;
  assign w_op_onehot = $onehot(r_op);

  always_comb begin
    w_state_nxt = r_state;
    req_ready_o = '0;
    fpu_op_o    = 4'b0000;
    case (r_state)
      IDLE: begin
        if (w_grant) begin
          req_ready_o[w_win] = 1'b1;
          w_state_nxt        = EXEC;
        end
      end
      EXEC: begin
        fpu_op_o    = r_op;
        w_state_nxt = RESP;
      end
      RESP: begin
        if (resp_ready_i) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_id    <= '0;
      r_op    <= 4'b0000;
      r_a     <= 16'h0000;
      r_b     <= 16'h0000;
      r_data  <= 16'h0000;
      r_ovf   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_grant) begin
        r_ptr <= (w_win == IDW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        r_id  <= w_win;
        r_op  <= req_op_i[4*w_win +: 4];
        r_a   <= req_a_i[16*w_win +: 16];
        r_b   <= req_b_i[16*w_win +: 16];
      end
      // Non-one-hot ops return a quiet NaN regardless of what the FPU produced.
      if (r_state == EXEC) begin
        r_err  <= !w_op_onehot;
        r_data <= w_op_onehot ? fpu_out_i : c_qnan;
        r_ovf  <= w_op_onehot & fpu_overflow_i;
      end
    end
  end

  assign resp_valid_o    = (r_state == RESP);
  assign resp_id_o       = r_id;
  assign resp_data_o     = r_data;
  assign resp_overflow_o = r_ovf;
  assign resp_err_o      = r_err;
  assign fpu_in1_o       = r_a;
  assign fpu_in2_o       = r_b;

endmodule
`default_nettype wire

// File: tb/tb_fpu_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_fpu_rr_scheduler
// Brief   : Self-checking bench for fpu_rr_scheduler with a stand-in FPU.
// Revision: 1.0
// ============================================================================
module tb_fpu_rr_scheduler;

  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic          clk;
  logic          rst;
  logic [3:0]    req_valid;
  logic [15:0]   req_op;
  logic [63:0]   req_a;
  logic [63:0]   req_b;
  logic [3:0]    req_ready;
  logic          resp_valid;
  logic          resp_ready;
  logic [1:0]    resp_id;
  logic [15:0]   resp_data;
  logic          resp_ovf;
  logic          resp_err;
  logic [3:0]    fpu_op;
  logic [15:0]   fpu_in1;
  logic [15:0]   fpu_in2;
  logic [15:0]   fpu_out;
  logic          fpu_ovf;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;

  fpu_rr_scheduler #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid_i     (req_valid),
    .req_op_i        (req_op),
    .req_a_i         (req_a),
    .req_b_i         (req_b),
    .req_ready_o     (req_ready),
    .resp_valid_o    (resp_valid),
    .resp_ready_i    (resp_ready),
    .resp_id_o       (resp_id),
    .resp_data_o     (resp_data),
    .resp_overflow_o (resp_ovf),
    .resp_err_o      (resp_err),
    .fpu_op_o        (fpu_op),
    .fpu_in1_o       (fpu_in1),
    .fpu_in2_o       (fpu_in2),
    .fpu_out_i       (fpu_out),
    .fpu_overflow_i  (fpu_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in FPU: exact bfloat16 answers for the known vectors, a hash otherwise.
  function automatic logic [16:0] fpu_ref(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b);
    if (op == 4'b0001 && a == 16'h3F80 && b == 16'h4000) return {1'b0, 16'h4040};
    if (op == 4'b0100 && a == 16'h4000 && b == 16'h4040) return {1'b0, 16'h40C0};
    if (op == 4'b0100 && a == 16'h7F7F && b == 16'h4000) return {1'b1, 16'h7F80};
    return {a[15] ^ b[14] ^ op[3], (a + {b[7:0], b[15:8]}) ^ {op, op, op, op}};
  endfunction

  always_comb {fpu_ovf, fpu_out} = fpu_ref(fpu_op, fpu_in1, fpu_in2);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level reference: one job in flight, response two cycles after grant.
  bit          m_busy;
  int          m_ptr;
  int          m_id;
  longint      cyc = 0;
  longint      m_gcyc;
  logic [3:0]  m_op;
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic [15:0] m_data;
  logic        m_ovf;
  logic        m_err;
  int          win;
  logic [3:0]  e_ready;
  bit          e_valid;
  logic [3:0]  last_ready;

  always @(negedge clk) begin
    last_ready = req_ready;
    if (rst) begin
      m_busy = 1'b0;
      m_ptr  = 0;
      m_a    = 16'h0;
      m_b    = 16'h0;
    end else begin
      win = -1;
      if (!m_busy)
        for (int k = 0; k < NREQ; k++)
          if (win < 0 && req_valid[(m_ptr + k) % NREQ]) win = (m_ptr + k) % NREQ;
      e_ready = (win >= 0) ? (4'b0001 << win) : 4'b0000;
      e_valid = m_busy && (cyc - m_gcyc >= 2);
      chk("m_req_ready", 32'(req_ready), 32'(e_ready));
      chk("m_resp_valid", 32'(resp_valid), 32'(e_valid));
      chk("m_fpu_op", 32'(fpu_op), (m_busy && cyc == m_gcyc + 1) ? 32'(m_op) : 32'd0);
      chk("m_fpu_in1", 32'(fpu_in1), 32'(m_a));
      chk("m_fpu_in2", 32'(fpu_in2), 32'(m_b));
      if (e_valid) begin
        chk("m_resp_id", 32'(resp_id), 32'(m_id));
        chk("m_resp_data", 32'(resp_data), 32'(m_data));
        chk("m_resp_ovf", 32'(resp_ovf), 32'(m_ovf));
        chk("m_resp_err", 32'(resp_err), 32'(m_err));
      end
      if (win >= 0) begin
        m_busy = 1'b1;
        m_gcyc = cyc;
        m_ptr  = (win + 1) % NREQ;
        m_id   = win;
        m_op   = req_op[4*win +: 4];
        m_a    = req_a[16*win +: 16];
        m_b    = req_b[16*win +: 16];
        m_err  = !$onehot(m_op);
        {m_ovf, m_data} = m_err ? {1'b0, 16'h7FC0} : fpu_ref(m_op, m_a, m_b);
      end else if (e_valid && resp_ready) begin
        m_busy = 1'b0;
      end
    end
    cyc++;
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [15:0] a, input logic [15:0] b);
    req_valid[i]      = v;
    req_op[4*i +: 4]  = op;
    req_a[16*i +: 16] = a;
    req_b[16*i +: 16] = b;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_reqs();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Issues one request from an idle scheduler; returns at the first RESP sample.
  task automatic run_single(input int i, input logic [3:0] op, input logic [15:0] a,
                            input logic [15:0] b);
    set_req(i, 1'b1, op, a, b);
    @(negedge clk); chk("single_ready", 32'(req_ready), 32'(4'b0001 << i));
    @(posedge clk); #1;
    req_valid[i] = 1'b0;
    @(negedge clk); chk("single_fpu_op", 32'(fpu_op), 32'(op));
    @(posedge clk); #1;
    @(negedge clk); chk("single_valid", 32'(resp_valid), 32'd1);
  endtask

  logic [16:0] bp_exp;

  initial begin
    rst        = 1'b1;
    resp_ready = 1'b1;
    clear_reqs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_valid", 32'(resp_valid), 32'd0);
    chk("rst_ready", 32'(req_ready), 32'd0);
    chk("rst_data", 32'(resp_data), 32'd0);
    chk("rst_fpu_op", 32'(fpu_op), 32'd0);
    @(posedge clk); #1;

    // Single add
    run_single(0, 4'b0001, 16'h3F80, 16'h4000);
    chk("add_data", 32'(resp_data), 32'h4040);
    chk("add_id", 32'(resp_id), 32'd0);
    chk("add_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;
    @(negedge clk); chk("add_done", 32'(resp_valid), 32'd0);
    @(posedge clk); #1;

    // Fairness with all requesters permanently valid
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'b0100, 16'h4000, 16'h4040);
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      chk("fair_ready", 32'(req_ready), (c % 3 == 0) ? 32'(4'b0001 << ((c / 3) % 4)) : 32'd0);
      if (c % 3 == 2) begin
        chk("fair_data", 32'(resp_data), 32'h40C0);
        chk("fair_id", 32'(resp_id), 32'((c / 3) % 4));
      end
      @(posedge clk); #1;
    end
    clear_reqs();

    // Back-pressure: req 1 wins (ptr = 1), req 3 waits behind it
    bp_exp = fpu_ref(4'b0001, 16'h4000, 16'h3F80);
    resp_ready = 1'b0;
    set_req(1, 1'b1, 4'b0001, 16'h4000, 16'h3F80);
    set_req(3, 1'b1, 4'b0010, 16'h4040, 16'h3F80);
    @(negedge clk); chk("bp_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    req_valid[1] = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(resp_valid), 32'd1);
      chk("bp_hold_data", 32'(resp_data), 32'(bp_exp[15:0]));
      chk("bp_hold_ready", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
    end
    resp_ready = 1'b1;
    @(negedge clk); chk("bp_release_valid", 32'(resp_valid), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("bp_idle_valid", 32'(resp_valid), 32'd0);
    chk("bp_next_grant", 32'(req_ready), 32'b1000);
    @(posedge clk); #1;
    req_valid[3] = 1'b0;
    repeat (2) begin @(posedge clk); #1; end

    // Illegal op
    run_single(2, 4'b0011, 16'h1234, 16'h5678);
    chk("ill_err", 32'(resp_err), 32'd1);
    chk("ill_data", 32'(resp_data), 32'h7FC0);
    chk("ill_ovf", 32'(resp_ovf), 32'd0);
    chk("ill_id", 32'(resp_id), 32'd2);
    @(posedge clk); #1;

    // Overflow pass-through
    run_single(3, 4'b0100, 16'h7F7F, 16'h4000);
    chk("ovf_flag", 32'(resp_ovf), 32'd1);
    chk("ovf_data", 32'(resp_data), 32'h7F80);
    chk("ovf_err", 32'(resp_err), 32'd0);
    @(posedge clk); #1;

    // Reset while a response is pending
    resp_ready = 1'b0;
    run_single(2, 4'b0010, 16'h3F80, 16'h4000);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    resp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) set_req(i, 1'b1, 4'b0001, 16'h3F80, 16'h4000);
    @(negedge clk);
    chk("mid_rst_valid", 32'(resp_valid), 32'd0);
    chk("mid_rst_id", 32'(resp_id), 32'd0);
    chk("mid_rst_data", 32'(resp_data), 32'd0);
    chk("mid_rst_err", 32'(resp_err), 32'd0);
    chk("mid_rst_in1", 32'(fpu_in1), 32'd0);
    chk("mid_rst_grant", 32'(req_ready), 32'b0001);
    @(posedge clk); #1;
    clear_reqs();
    repeat (3) begin @(posedge clk); #1; end

    // Randomized traffic, including occasional resets
    for (int t = 0; t < 3000; t++) begin
      rst        = ($urandom_range(0, 599) == 0);
      resp_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < NREQ; i++) begin
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        op = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'(1 << $urandom_range(0, 3));
        a  = ($urandom_range(0, 5) == 0) ? 16'h4000 : 16'($urandom);
        b  = ($urandom_range(0, 5) == 0) ? 16'h4040 : 16'($urandom);
        if (req_valid[i] && last_ready[i])
          set_req(i, 1'($urandom_range(0, 1)), op, a, b);
        else if (req_valid[i]) begin
          if ($urandom_range(0, 19) == 0) req_valid[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0)
          set_req(i, 1'b1, op, a, b);
      end
      @(posedge clk); #1;
    end
    rst        = 1'b0;
    resp_ready = 1'b1;
    clear_reqs();
    repeat (5) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fpu_rr_scheduler.md
Name: fpu_rr_scheduler

Overview:
Round-robin scheduler that shares one combinational bfloat16 `fpu` instance (ports op_i/in1_i/in2_i/out_o/overflow_o) between NREQ requesters. It arbitrates among the requesters and registers the winning operands into the FPU. It then captures the FPU result one cycle later and returns it through a single valid/ready response channel, tagged with the requester id. It sits between the issuing clients and the shared `fpu` in the arithmetic subsystem.

Parameters:
NREQ, 4, number of requesters (2..8)
IDW, 2, requester id width, equals clog2(NREQ)

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
req_valid_i  input  NREQ  per-requester request valid
req_op_i  input  4*NREQ  per-requester op, one-hot: 0001 add, 0010 sub, 0100 mul, 1000 div; slice i at [4i+3:4i]
req_a_i  input  16*NREQ  per-requester operand A (bfloat16), slice i at [16i+15:16i]
req_b_i  input  16*NREQ  per-requester operand B (bfloat16)
req_ready_o  output  NREQ  one-hot accept strobe
resp_valid_o  output  1  response valid
resp_ready_i  input  1  response consumer ready
resp_id_o  output  IDW  index of the requester that owns the response
resp_data_o  output  16  bfloat16 result
resp_overflow_o  output  1  overflow flag captured from the FPU
resp_err_o  output  1  op was not one-hot
fpu_op_o  output  4  to fpu op_i
fpu_in1_o  output  16  to fpu in1_i
fpu_in2_o  output  16  to fpu in2_i
fpu_out_i  input  16  from fpu out_o
fpu_overflow_i  input  1  from fpu overflow_o

Behaviour:
- Clock is clk; reset rst is synchronous and active-high.
- FSM states: IDLE, EXEC, RESP. Reset forces:
  - state IDLE
  - round-robin pointer ptr = 0
  - all operand/result registers 0
  - req_ready_o = 0, resp_valid_o = 0, resp_id_o = 0, resp_data_o = 0, resp_overflow_o = 0, resp_err_o = 0
  - fpu_op_o = 0000, fpu_in1_o = 0, fpu_in2_o = 0
- Arbitration:
  - Winner is the first i with req_valid_i[i] = 1, scanning ptr, ptr+1, … mod NREQ.
  - After a grant to i, ptr becomes (i+1) mod NREQ.
  - ptr changes only on a grant.
- IDLE, some request valid:
  - req_ready_o[winner] = 1 combinationally, in this cycle only.
  - Latch op, A, B and id into the registers; go to EXEC.
- IDLE, no request valid: req_ready_o = 0; stay in IDLE.
- req_ready_o is 0 in EXEC and RESP. At most one bit of req_ready_o is set in any cycle.
- The request handshake is valid & ready. Requesters hold op/A/B stable while valid and not ready.
- fpu_op_o/fpu_in1_o/fpu_in2_o are driven from the registers in EXEC. fpu_op_o = 0000 in IDLE and RESP; fpu_in1_o/fpu_in2_o keep their values.
- EXEC (1 cycle):
  - Capture fpu_out_i into resp_data_o and fpu_overflow_i into resp_overflow_o.
  - resp_err_o = 1 if the latched op is not one-hot. In that case resp_data_o is forced to 16'h7FC0 and resp_overflow_o to 0.
  - Go to RESP.
- RESP:
  - resp_valid_o = 1; data/id/overflow/err stay stable.
  - On resp_valid_o & resp_ready_i, go to IDLE and deassert resp_valid_o next cycle.
  - No new grant is made in the handshake cycle.
- Latency: grant at cycle T, resp_valid_o at T+2. Minimum issue interval is 3 cycles.
- A requester that deasserts valid before its grant is simply not served. No request is lost once accepted.
- rst asserted in any state, including mid-RESP, returns everything to the reset values on the next edge and discards the pending response.

Test Plan:
- Single request: req 0 only, add, A = 3F80 (1.0), B = 4000 (2.0) -> req_ready_o = 0001 for 1 cycle; 2 cycles later resp_valid_o = 1, data = 4040, id = 0, err = 0.
- Fairness: all 4 requesters held valid with mul 4000 × 4040 -> grants in order 0,1,2,3,0, spaced 3 cycles apart; every response data = 40C0 with the matching id.
- Back-pressure: resp_ready_i held low for 5 cycles during RESP -> resp_valid_o and data stay stable, no req_ready_o pulses; release -> IDLE next cycle, then the next grant.
- Illegal op: req 2, op = 0011 -> resp_err_o = 1, data = 7FC0, overflow = 0, id = 2.
- Overflow pass-through: mul 7F7F × 4000 with the real fpu attached -> resp_overflow_o = 1 and resp_data_o equal to the fpu output.
- Reset mid-RESP: rst pulsed while resp_valid_o = 1 -> next cycle all outputs 0; the next grant goes to requester 0 (ptr = 0).
